xup_1_to_2_demux_stream: RTL

Registered 1-to-2 stream demultiplexer carrying a SIZE-bit vector, using a valid/ready handshake.
- Each accepted input beat is steered by sel to output 0 (sel=0) or output 1 (sel=1).
- The beat is held in that output's one-entry buffer until the output handshake completes.
- Used wherever one producer feeds two consumers, e.g. splitting a datapath between two processing units.

---
 rtl/xup_1_to_2_demux_stream.sv | 132 +++++++++++++
 1 files changed

// File: rtl/xup_1_to_2_demux_stream.sv
// Registered 1-to-2 valid/ready stream demux with a one-entry buffer per output.
// Define XUP_DEMUX_PACKET_LOCK_EN to hold the destination for the length of an a_last-delimited packet.

module xup_demux_slot #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load,
    input  logic [SIZE-1:0] d,
    input  logic            ready,
    output logic [SIZE-1:0] q,
    output logic            valid,
    output logic            free
);

    // Free also when draining this cycle, so a new beat can replace the old one.
    assign free = ~valid | ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

module xup_1_to_2_demux_stream #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [SIZE-1:0] a,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic            a_last,
    input  logic            sel,
    output logic [SIZE-1:0] y0,
    output logic            y0_valid,
    input  logic            y0_ready,
    output logic [SIZE-1:0] y1,
    output logic            y1_valid,
    input  logic            y1_ready
);

    localparam int NUM_OUT = 2;

    logic [NUM_OUT-1:0][SIZE-1:0] y_q;
    logic [NUM_OUT-1:0]           y_vld;
    logic [NUM_OUT-1:0]           y_rdy;
    logic [NUM_OUT-1:0]           free;
    logic [NUM_OUT-1:0]           load;
    logic                         dst;

    assign y_rdy = {y1_ready, y0_ready};

`ifdef XUP_DEMUX_PACKET_LOCK_EN
    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t state, state_nxt;
    logic        lock_sel, lock_sel_nxt;
    logic        accept;

    assign dst    = (state == LOCKED) ? lock_sel : sel;
    assign accept = a_valid & a_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= UNLOCKED;
            lock_sel <= 1'b0;
        end else begin
            state    <= state_nxt;
            lock_sel <= lock_sel_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        lock_sel_nxt = lock_sel;
        case (state)
            UNLOCKED: begin
                // A single-beat packet (a_last on the first beat) never locks.
                if (accept && !a_last) begin
                    state_nxt    = LOCKED;
                    lock_sel_nxt = sel;
                end
            end
            LOCKED: begin
                if (accept && a_last) state_nxt = UNLOCKED;
            end
            default: state_nxt = UNLOCKED;
        endcase
    end
`else
    logic unused_last;
    assign unused_last = a_last;
    assign dst         = sel;
`endif

    // Held low in reset; otherwise never looks at a_valid.
    assign a_ready = reset_n & free[dst];

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
        assign load[k] = a_valid & a_ready & (dst == (k == 1));

        xup_demux_slot #(.SIZE(SIZE)) u_slot (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (load[k]),
            .d       (a),
            .ready   (y_rdy[k]),
            .q       (y_q[k]),
            .valid   (y_vld[k]),
            .free    (free[k])
        );
    end

    assign y0       = y_q[0];
    assign y1       = y_q[1];
    assign y0_valid = y_vld[0];
    assign y1_valid = y_vld[1];

endmodule
